sram_ctrl: RTL and testbench

Initiator-side controller that drives the single-port SRAM block. It sits between the processor datapath and the SRAM. It accepts one read or write request at a time over a valid/ready handshake, sequences the SRAM's cs/wr_en/addr/wr_data pins, and samples the SRAM's registered-address read data at the correct edge. It returns a one-cycle response pulse and can optionally zero-fill the whole array after reset.

---
 rtl/sram_ctrl.sv | 159 +++++++++++++++
 tb/tb_sram_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: initiator-side sequencer for a single-port SRAM with a registered address.
// Takes one valid/ready request at a time, returns a one-cycle response, and can zero-fill the array after reset.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata  request fields
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response pulse, read data, out-of-range flag
//   init_done                  clear sequence finished
//   sram_cs/sram_wr_en/sram_addr/sram_wr_data/sram_rd_data  SRAM pins
module sram_ctrl #(
  parameter int N              = 4,
  parameter int W              = 4,
  parameter int A              = (N > 1) ? $clog2(N) : 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [A-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         init_done,
  output logic         sram_cs,
  output logic         sram_wr_en,
  output logic [A-1:0] sram_addr,
  output logic [W-1:0] sram_wr_data,
  input  logic [W-1:0] sram_rd_data
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCESS,
    S_RD_WAIT,
    S_RESP
  } state_e;

  // One extra bit so the word count itself is representable.
  localparam logic [A:0] NUM = (A+1)'(N);

  state_e       state_q;
  logic [A:0]   clr_q;
  logic         we_q;
  logic         err_q;
  logic         req_ready_q;
  logic         rsp_valid_q;
  logic [W-1:0] rsp_rdata_q;
  logic         rsp_err_q;
  logic         init_done_q;
  logic         cs_q;
  logic         wr_en_q;
  logic [A-1:0] addr_q;
  logic [W-1:0] wdata_q;

  logic         in_range;

  assign in_range = ({1'b0, req_addr} < NUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
      cs_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          // Issue one zero-write per cycle; leave once all N are out.
          if (clr_q == NUM) begin
            cs_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cs_q    <= 1'b1;
            wr_en_q <= 1'b1;
            addr_q  <= clr_q[A-1:0];
            wdata_q <= '0;
            clr_q   <= clr_q + 1'b1;
          end
        end
        S_IDLE: begin
          init_done_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            err_q       <= ~in_range;
            state_q     <= S_ACCESS;
            if (in_range) begin
              cs_q    <= 1'b1;
              wr_en_q <= req_we;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_ACCESS: begin
          // SRAM samples the pins at this edge. An out-of-range
          // request passes through here with cs low so its
          // response has the same one-cycle latency as a write.
          cs_q    <= 1'b0;
          wr_en_q <= 1'b0;
          if (err_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else if (we_q) begin
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          rsp_rdata_q <= sram_rd_data;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign init_done    = init_done_q;
  assign sram_cs      = cs_q;
  assign sram_wr_en   = wr_en_q;
  assign sram_addr    = addr_q;
  assign sram_wr_data = wdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: random and directed stimulus for sram_ctrl against a behavioural SRAM and a word-array model.
// Second instance covers CLEAR_ON_RESET=0.
module tb_sram_ctrl;

  localparam int N = 6;
  localparam int W = 4;
  localparam int A = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid, req_ready, req_we;
  logic [A-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid, rsp_err, init_done;
  logic [W-1:0] rsp_rdata;
  logic         sram_cs, sram_wr_en;
  logic [A-1:0] sram_addr;
  logic [W-1:0] sram_wr_data, sram_rd_data;

  sram_ctrl #(.N(N), .W(W), .A(A), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done),
    .sram_cs(sram_cs), .sram_wr_en(sram_wr_en),
    .sram_addr(sram_addr), .sram_wr_data(sram_wr_data),
    .sram_rd_data(sram_rd_data)
  );

  logic         rv1, rr1, rwe1, rsv1, rse1, id1, cs1, wen1;
  logic [2:0]   ra1, sa1;
  logic [W-1:0] rwd1, rsd1, swd1, srd1;

  assign srd1 = '0;

  sram_ctrl #(.N(5), .W(W), .A(3), .CLEAR_ON_RESET(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv1), .req_ready(rr1),
    .req_we(rwe1), .req_addr(ra1), .req_wdata(rwd1),
    .rsp_valid(rsv1), .rsp_rdata(rsd1), .rsp_err(rse1),
    .init_done(id1),
    .sram_cs(cs1), .sram_wr_en(wen1),
    .sram_addr(sa1), .sram_wr_data(swd1),
    .sram_rd_data(srd1)
  );

  // Behavioural SRAM: pins sampled on the rising edge, registered read address.
  logic [W-1:0] smem [N];
  logic [A-1:0] sar = '0;

  initial begin
    for (int i = 0; i < N; i++) smem[i] = W'($urandom);
  end

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_wr_en) smem[sram_addr] <= sram_wr_data;
      sar <= sram_addr;
    end
  end

  assign sram_rd_data = smem[sar];

  // Reference model
  logic [W-1:0] mem_m [N];
  logic [W-1:0] last_rd;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mem_m[i] = '0;
    last_rd = '0;
  endtask

  // Entered on the negedge at which rst_n was released.
  task automatic check_clear();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("clr_cycle",
          {sram_cs, sram_wr_en, req_ready, init_done, rsp_valid,
           sram_addr, sram_wr_data},
          {5'b11000, A'(i), W'(0)});
    end
    @(negedge clk);
    chk("clr_done", {sram_cs, sram_wr_en, req_ready, init_done, rsp_valid},
        5'b00110);
    model_reset();
  endtask

  // Entered on a negedge; returns on the negedge where ready is back.
  task automatic do_req(input bit we, input int addr,
                        input logic [W-1:0] wd, input bit hold);
    int n, lat, csn, exp_lat;
    bit bad;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = A'(addr);
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", req_ready, 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) begin
      req_valid = 1'b0;
      req_addr  = A'($urandom);
      req_wdata = W'($urandom);
    end
    bad = (addr >= N);
    chk("ready_low", req_ready, 0);
    if (!bad)
      chk("pins", {sram_wr_en, sram_addr, sram_wr_data},
          {we, A'(addr), wd});
    lat = 0;
    csn = 0;
    while (!rsp_valid && lat < 8) begin
      csn += int'(sram_cs);
      @(negedge clk);
      lat++;
    end
    csn += int'(sram_cs);
    exp_lat = bad ? 1 : (we ? 1 : 2);
    if (!bad) begin
      if (we) mem_m[addr] = wd;
      else    last_rd = mem_m[addr];
    end
    chk("latency", lat, exp_lat);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, bad);
    chk("rsp_rdata", rsp_rdata, last_rd);
    chk("cs_cycles", csn, bad ? 0 : 1);
    @(negedge clk);
    chk("pulse_end", {rsp_valid, rsp_err}, 0);
    chk("ready_back", req_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, pulses, cs_seen;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rv1 = 1'b0; rwe1 = 1'b0; ra1 = '0; rwd1 = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset_outs",
        {sram_cs, sram_wr_en, sram_addr, sram_wr_data, rsp_valid,
         rsp_rdata, rsp_err, req_ready, init_done}, 0);
    chk("u1_reset", {rr1, id1, rsv1, cs1}, 0);
    rst_n = 1'b1;
    fork
      check_clear();
      begin
        @(negedge clk);
        chk("u1_init", {id1, rr1}, 2'b11);
      end
    join

    // Directed
    do_req(1'b0, 2, 4'h0, 1'b0);
    do_req(1'b1, 1, 4'hA, 1'b0);
    do_req(1'b0, 1, 4'h0, 1'b0);
    do_req(1'b1, 0, 4'h3, 1'b0);
    do_req(1'b1, 3, 4'hC, 1'b0);
    do_req(1'b0, 3, 4'h0, 1'b1);
    do_req(1'b0, 0, 4'h0, 1'b1);
    req_valid = 1'b0;
    chk("rdata_hold", rsp_rdata, 4'h3);
    do_req(1'b0, 7, 4'h0, 1'b0);
    do_req(1'b1, 6, 4'h5, 1'b0);

    // Random
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom), int'($urandom_range(0, 7)), W'($urandom),
             1'($urandom));
    end
    req_valid = 1'b0;

    // Reset during CLEAR at clr=2
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sram_cs && sram_addr == 2) && n < 10);
    chk("clr_at2", {sram_cs, sram_addr}, {1'b1, 3'd2});
    #2 rst_n = 1'b0;
    #1 chk("async_clr", {sram_cs, sram_wr_en, rsp_valid, init_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_clear();
    for (int i = 0; i < N; i++) do_req(1'b0, i, 4'h0, 1'b0);

    // Reset during RD_WAIT
    do_req(1'b1, 3, 4'h9, 1'b0);
    do_req(1'b0, 3, 4'h0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rdw",
           {sram_cs, rsp_valid, rsp_rdata, req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_clear();
    do_req(1'b0, 3, 4'h0, 1'b0);

    // CLEAR_ON_RESET=0 instance, request held valid out of range
    chk("u1_ready", rr1, 1);
    rv1 = 1'b1;
    rwe1 = 1'b0;
    ra1 = 3'd6;
    pulses = 0;
    cs_seen = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cs_seen += int'(cs1);
      if (rsv1) begin
        pulses++;
        chk("u1_err", rse1, 1);
      end
    end
    rv1 = 1'b0;
    chk("u1_pulses", pulses, 3);
    chk("u1_no_cs", cs_seen, 0);
    chk("u1_rdata", rsd1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
